// File: rtl/pingpong_sched_pkg.sv
// pingpong_sched_pkg
//   Shared types for the ping-pong bank scheduler.
//   bank_state_e : life cycle of one buffer bank
//   rd_state_e   : drain-side read FSM states
//   STALL_CNT_W  : width of the optional stall counter
package pingpong_sched_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_READ = 2'd1,
    RD_WAIT = 2'd2
  } rd_state_e;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/pingpong_bank_sched_if.sv
// pingpong_bank_sched_if
//   Bundles the fill-side stream, the bank write/read controls and the
//   matmul handshake of one ping-pong bridge buffer.
//   Ports (signals): in_valid/in_ready, wr_en/wr_bank/wr_addr, acc_done,
//   rd_en/rd_bank/rd_addr/rd_valid, enable_matmul, tile_done, bank_full,
//   rd_state_dbg (read FSM state for observation).
//   Modports: master = scheduler, slave = stream source / matmul side.
//
// Handshake: a word transfers on every clock edge where in_valid and
//   in_ready are both high; wr_en is exactly that transfer condition.
//   in_ready does not depend on in_valid. acc_done is a single-cycle pulse
//   and is only acted on while the read FSM waits for it.
interface pingpong_bank_sched_if #(
  parameter int ADDR_WIDTH = 8
);
  import pingpong_sched_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic                  wr_en;
  logic                  wr_bank;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  acc_done;
  logic                  rd_en;
  logic                  rd_bank;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_valid;
  logic                  enable_matmul;
  logic                  tile_done;
  logic [1:0]            bank_full;
  rd_state_e             rd_state_dbg;

  modport master (
    input  in_valid, acc_done,
    output in_ready, wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr,
           rd_valid, enable_matmul, tile_done, bank_full, rd_state_dbg
  );

  modport slave (
    output in_valid, acc_done,
    input  in_ready, wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr,
           rd_valid, enable_matmul, tile_done, bank_full, rd_state_dbg
  );

endinterface

// File: rtl/pingpong_bank_sched_rd_valid_pipe.sv
// rd_valid_pipe
//   Delays the registered read enable by LATENCY cycles so that it lines up
//   with the bank's registered read data. Cleared only by reset.
//   Ports: clk, rst (async, active-high), din (rd_en), dout (rd_valid).
module rd_valid_pipe #(
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [LATENCY-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= (sr << 1) | LATENCY'(din);
  end

  assign dout = sr[LATENCY-1];

endmodule

// File: rtl/pingpong_bank_sched.sv
// pingpong_bank_sched
//   Schedules the two ping-pong banks of one bridge buffer. The fill side
//   writes streamed words into the write bank; the drain side replays a full
//   bank DRAIN_PASSES times into the matmul, waiting for acc_done after each
//   pass, then frees the bank and moves to the other one.
//   Ports: clk, rst (async, active-high), bus (pingpong_bank_sched_if.master),
//          stall_cnt (only when PPB_STALL_CNT_EN is defined).
//   Optional feature macro: PPB_STALL_CNT_EN adds a 16-bit saturating count
//   of cycles where in_valid is held while in_ready is low.
module pingpong_bank_sched
  import pingpong_sched_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int FILL_DEPTH   = 16,
  parameter int DRAIN_DEPTH  = 16,
  parameter int DRAIN_PASSES = 4,
  parameter int RD_LATENCY   = 2
) (
  input  logic clk,
  input  logic rst,
  pingpong_bank_sched_if.master bus
`ifdef PPB_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam int PASS_W = $clog2(DRAIN_PASSES) + 1;
  localparam logic [ADDR_WIDTH-1:0] FILL_LAST  = ADDR_WIDTH'(FILL_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] DRAIN_LAST = ADDR_WIDTH'(DRAIN_DEPTH - 1);
  localparam logic [PASS_W-1:0]     PASS_LAST  = PASS_W'(DRAIN_PASSES - 1);

  bank_state_e           bank_state [2];
  logic                  wbank;
  logic                  rbank;
  logic [ADDR_WIDTH-1:0] wr_cnt;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic [PASS_W-1:0]     pass;
  rd_state_e             rd_state;
  rd_state_e             rd_state_nxt;

  logic                  ready;
  logic                  accept;
  logic                  pass_last;
  logic                  drain_start;
  logic                  rd_issue;
  logic                  pass_again;
  logic                  release_bank;
  logic                  rd_en_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  tile_done_q;

  // Gated by rst so in_ready (and wr_en) read 0 while reset is held.
  assign ready     = !rst && (bank_state[wbank] == EMPTY || bank_state[wbank] == FILLING);
  assign accept    = bus.in_valid && ready;
  assign pass_last = (pass == PASS_LAST);

  // Read FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_state <= RD_IDLE;
    else     rd_state <= rd_state_nxt;
  end

  // Read FSM: next state
  always_comb begin
    rd_state_nxt = rd_state;
    unique case (rd_state)
      RD_IDLE: if (bank_state[rbank] == FULL) rd_state_nxt = RD_READ;
      RD_READ: if (rd_cnt == DRAIN_LAST)      rd_state_nxt = RD_WAIT;
      RD_WAIT: if (bus.acc_done)              rd_state_nxt = pass_last ? RD_IDLE : RD_READ;
      default:                                rd_state_nxt = RD_IDLE;
    endcase
  end

  // Read FSM: outputs / datapath controls
  always_comb begin
    drain_start  = 1'b0;
    rd_issue     = 1'b0;
    pass_again   = 1'b0;
    release_bank = 1'b0;
    unique case (rd_state)
      RD_IDLE: drain_start = (bank_state[rbank] == FULL);
      RD_READ: rd_issue    = 1'b1;
      RD_WAIT: begin
        pass_again   = bus.acc_done && !pass_last;
        release_bank = bus.acc_done && pass_last;
      end
      default: ;
    endcase
  end

  // Bank states, counters and registered read outputs. Fill and drain never
  // target the same bank in one cycle: a bank being filled is EMPTY/FILLING
  // while the drain side only acts on FULL/DRAINING banks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_state[0] <= EMPTY;
      bank_state[1] <= EMPTY;
      wbank         <= 1'b0;
      rbank         <= 1'b0;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      pass          <= '0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      tile_done_q   <= 1'b0;
    end else begin
      if (accept) begin
        if (wr_cnt == FILL_LAST) begin
          bank_state[wbank] <= FULL;
          wr_cnt            <= '0;
          wbank             <= ~wbank;
        end else begin
          bank_state[wbank] <= FILLING;
          wr_cnt            <= wr_cnt + 1'b1;
        end
      end
      if (drain_start) begin
        bank_state[rbank] <= DRAINING;
        rd_cnt            <= '0;
        pass              <= '0;
      end
      if (rd_issue) rd_cnt <= (rd_cnt == DRAIN_LAST) ? '0 : rd_cnt + 1'b1;
      if (pass_again) begin
        pass   <= pass + 1'b1;
        rd_cnt <= '0;
      end
      if (release_bank) begin
        bank_state[rbank] <= EMPTY;
        rbank             <= ~rbank;
      end
      rd_en_q     <= rd_issue;
      if (rd_issue) rd_addr_q <= rd_cnt;
      tile_done_q <= release_bank;
    end
  end

  rd_valid_pipe #(.LATENCY(RD_LATENCY)) u_rd_valid_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  (rd_en_q),
    .dout (bus.rd_valid)
  );

  assign bus.in_ready      = ready;
  assign bus.wr_en         = accept;
  assign bus.wr_bank       = wbank;
  assign bus.wr_addr       = wr_cnt;
  assign bus.rd_en         = rd_en_q;
  assign bus.rd_bank       = rbank;
  assign bus.rd_addr       = rd_addr_q;
  assign bus.enable_matmul = (rd_state == RD_READ);
  assign bus.tile_done     = tile_done_q;
  assign bus.bank_full[0]  = (bank_state[0] == FULL) || (bank_state[0] == DRAINING);
  assign bus.bank_full[1]  = (bank_state[1] == FULL) || (bank_state[1] == DRAINING);
  assign bus.rd_state_dbg  = rd_state;

`ifdef PPB_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (bus.in_valid && !ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pingpong_bank_sched.sv
// tb_pingpong_bank_sched
//   Directed steps followed by random traffic, checked against a tile-level
//   model: occupancy = tiles filled - tiles released, an expected read queue
//   of {bank, addr}, and rd_valid as rd_en delayed by the read latency.
module tb_pingpong_bank_sched;
  import pingpong_sched_pkg::*;

  localparam int AW = 8;
  localparam int FD = 4;
  localparam int DD = 4;
  localparam int DP = 2;
  localparam int RL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // clock / reset
  always #5 clk = ~clk;

  pingpong_bank_sched_if #(.ADDR_WIDTH(AW)) bus ();
`ifdef PPB_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  pingpong_bank_sched #(
    .ADDR_WIDTH  (AW),
    .FILL_DEPTH  (FD),
    .DRAIN_DEPTH (DD),
    .DRAIN_PASSES(DP),
    .RD_LATENCY  (RL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PPB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // scoreboard / model
  logic [AW:0] exp_q[$];
  logic        en_hist[$];
  int          filled, released, fill_cnt, pass_m, k;
  logic        td_exp;

  int t_en[8] = '{0, 0, 1, 1, 1, 1, 0, 0};
  int t_rv[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  int t_mm[8] = '{0, 1, 1, 1, 1, 0, 0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    filled   = 0;
    released = 0;
    fill_cnt = 0;
    pass_m   = 0;
    k        = 0;
    td_exp   = 1'b0;
    exp_q.delete();
    en_hist.delete();
    repeat (RL) en_hist.push_back(1'b0);
  endtask

  function automatic logic [1:0] bf_exp();
    logic [1:0] r;
    r = 2'b00;
    for (int t = released; t < filled; t++) r[t % 2] = 1'b1;
    return r;
  endfunction

  // One cycle: drive inputs after the falling edge, check, then advance the
  // model to what the coming rising edge should do.
  task automatic step(input logic iv, input logic ad);
    logic       exp_ready;
    logic       exp_wr;
    logic [AW:0] e;
    @(negedge clk);
    bus.in_valid = iv;
    bus.acc_done = ad;
    #1;
    exp_ready = (filled - released) < 2;
    exp_wr    = iv && exp_ready;
    chk("in_ready", bus.in_ready, exp_ready);
    chk("wr_en", bus.wr_en, exp_wr);
    if (exp_wr) begin
      chk("wr_bank", bus.wr_bank, filled % 2);
      chk("wr_addr", bus.wr_addr, fill_cnt);
    end
    chk("bank_full", bus.bank_full, bf_exp());
    chk("tile_done", bus.tile_done, td_exp);
    chk("rd_valid", bus.rd_valid, en_hist[0]);
    void'(en_hist.pop_front());
    en_hist.push_back(bus.rd_en);
    if (bus.rd_en === 1'b1) begin
      if (k == DD) begin
        chk("rd_en_while_waiting", bus.rd_en, 0);
      end else if (exp_q.size() == 0) begin
        chk("rd_en_unexpected", bus.rd_en, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rd_bank_addr", {bus.rd_bank, bus.rd_addr}, e);
        k++;
      end
    end
    td_exp = 1'b0;
    if (exp_wr) begin
      fill_cnt++;
      if (fill_cnt == FD) begin
        fill_cnt = 0;
        repeat (DP) begin
          for (int a = 0; a < DD; a++) begin
            e[AW]     = filled[0];
            e[AW-1:0] = AW'(a);
            exp_q.push_back(e);
          end
        end
        filled++;
      end
    end
    if (ad && k == DD) begin
      k = 0;
      pass_m++;
      if (pass_m == DP) begin
        pass_m = 0;
        released++;
        td_exp = 1'b1;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.acc_done = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.acc_done = 1'b0;
    model_reset();

    // 1: reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_bank", bus.wr_bank, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_rd_bank", bus.rd_bank, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_enable_matmul", bus.enable_matmul, 0);
    chk("rst_tile_done", bus.tile_done, 0);
    chk("rst_bank_full", bus.bank_full, 0);
    rst = 1'b0;
    step(1'b0, 1'b0);
    chk("in_ready_after_rst", bus.in_ready, 1);

    // 2: fill bank0, then one pass of reads
    repeat (FD) step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0);
      if (i == 0) begin
        chk("bank_full_after_fill0", bus.bank_full, 2'b01);
        chk("wr_bank_after_fill0", bus.wr_bank, 1);
      end
      chk("pass0_rd_en", bus.rd_en, t_en[i]);
      chk("pass0_rd_valid", bus.rd_valid, t_rv[i]);
      chk("pass0_enable_matmul", bus.enable_matmul, t_mm[i]);
    end

    // 3: fill bank1 while bank0 waits -> both banks held
    repeat (FD) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("both_full_bank_full", bus.bank_full, 2'b11);
    chk("both_full_in_ready", bus.in_ready, 0);
    chk("both_full_wr_en", bus.wr_en, 0);

    // 4: acknowledge both passes of bank0
    for (int i = 0; i < 40 && released < 1; i++) step(1'b0, k == DD);
    chk("tile0_released_in_budget", released, 1);
    step(1'b0, 1'b0);
    chk("release_tile_done", bus.tile_done, 1);
    chk("release_bank_full", bus.bank_full, 2'b10);
    chk("release_in_ready", bus.in_ready, 1);
    step(1'b0, 1'b0);
    chk("bank1_enable_matmul", bus.enable_matmul, 1);
    step(1'b0, 1'b0);
    chk("bank1_rd_en", bus.rd_en, 1);
    chk("bank1_rd_bank", bus.rd_bank, 1);

    // 5: reset in the middle of a read pass
    rst = 1'b1;
    #1;
    chk("midrst_rd_en", bus.rd_en, 0);
    chk("midrst_enable_matmul", bus.enable_matmul, 0);
    chk("midrst_bank_full", bus.bank_full, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0);
    chk("refill_wr_bank", bus.wr_bank, 0);
    chk("refill_wr_addr", bus.wr_addr, 0);

    // random traffic, acc_done sprinkled everywhere (ignored outside the wait)
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) < 60,
           (k == DD) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0));
    end
    for (int i = 0; i < 400 && (filled != released || exp_q.size() != 0); i++)
      step(1'b0, k == DD);
    chk("drain_reads_left", exp_q.size(), 0);
    chk("drain_tiles_left", filled - released, 0);

`ifdef PPB_STALL_CNT_EN
    // 6: stall counter
    apply_reset();
    repeat (2 * FD) step(1'b1, 1'b0);
    repeat (5) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("stall_cnt_5", stall_cnt, 5);
    repeat (70000) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("stall_cnt_sat", stall_cnt, 16'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
